gaussian_kernel_norm: RTL

- Parametrised successor to the single-size kernel normaliser. Takes a raw 1-D symmetric Gaussian profile (centre weight plus radius weights) and a runtime odd kernel size.
- Builds the separable 2-D kernel as an outer product and normalises it to FRAC fractional bits with a multi-cycle restoring divider. No combinational divide.
- Computes only one quadrant and mirrors each result into four positions.
- Feeds the convolution stage. The kernel output register updates atomically on completion.

---
 rtl/gaussian_kernel_norm_if.sv | 31 +++
 rtl/gaussian_kernel_norm.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gaussian_kernel_norm_if.sv
// Request/result bundle between a kernel-build requester (master) and
// gaussian_kernel_norm (slave).
interface gaussian_kernel_norm_if #(
    parameter int MAX_KERNEL = 7,
    parameter int IN_W       = 8,
    parameter int COEF_W     = 8
);
    localparam int MAX_R = (MAX_KERNEL - 1) / 2;
    localparam int KS_W  = $clog2(MAX_KERNEL + 1);
    localparam int S_W   = 2 * (IN_W + $clog2(MAX_KERNEL));

    logic                                    start;
    logic                                    abort;
    logic [KS_W-1:0]                         kernel_size;
    logic [(MAX_R+1)*IN_W-1:0]               raw_w;
    logic [MAX_KERNEL*MAX_KERNEL*COEF_W-1:0] kernel;
    logic [S_W-1:0]                          sum_out;
    logic                                    busy;
    logic                                    done;
    logic                                    err;

    modport master (
        output start, abort, kernel_size, raw_w,
        input  kernel, sum_out, busy, done, err
    );

    modport slave (
        input  start, abort, kernel_size, raw_w,
        output kernel, sum_out, busy, done, err
    );
endinterface

// File: rtl/gaussian_kernel_norm.sv
// Separable 2-D Gaussian kernel builder: computes one quadrant of the outer
// product, normalises each entry with a restoring divider and mirrors it.
module gaussian_kernel_norm #(
    parameter int MAX_KERNEL = 7,
    parameter int IN_W       = 8,
    parameter int COEF_W     = 8,
    parameter int FRAC       = 8,
    parameter int ROUND      = 0
) (
    input  logic                  clk,
    input  logic                  n_rst,
    gaussian_kernel_norm_if.slave bus
);
    localparam int MAX_R  = (MAX_KERNEL - 1) / 2;
    localparam int KS_W   = $clog2(MAX_KERNEL + 1);
    localparam int RW     = (MAX_R > 0) ? $clog2(MAX_R + 1) : 1;
    localparam int ACC_W  = IN_W + $clog2(MAX_KERNEL);
    localparam int S_W    = 2 * ACC_W;
    localparam int NUM_W  = 2 * IN_W + FRAC + 1;
    localparam int NK     = MAX_KERNEL * MAX_KERNEL;
    localparam int IDX_W  = $clog2(NK);
    localparam int CW_W   = $clog2(COEF_W + 1);
    localparam int WIDE_W = NUM_W + S_W;
    localparam logic [COEF_W-1:0] COEF_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE, ST_CHECK, ST_SUM, ST_SQUARE, ST_MUL, ST_DIV, ST_WR, ST_FIN
    } state_t;

    state_t               state_q, state_d;
    logic [KS_W-1:0]      n_q, n_d;
    logic [RW-1:0]        r_q, r_d, d_q, d_d, i_q, i_d, j_q, j_d;
    logic [IN_W-1:0]      raw_q [MAX_R+1];
    logic [IN_W-1:0]      raw_d [MAX_R+1];
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [S_W-1:0]       s_q, s_d, rem_q, rem_d;
    logic [COEF_W:0]      numlo_q, numlo_d, quo_q, quo_d;
    logic [CW_W-1:0]      cnt_q, cnt_d;
    logic                 sat_q, sat_d, err_q, err_d, aborted_q, aborted_d;
    logic                 busy_q, busy_d, done_q, done_d;
    logic [COEF_W-1:0]    work_q [NK];
    logic [COEF_W-1:0]    work_d [NK];
    logic [COEF_W-1:0]    kernel_q [NK];
    logic [COEF_W-1:0]    kernel_d [NK];
    logic [S_W-1:0]       sum_q, sum_d;

    logic [2*IN_W-1:0]    p;
    logic [NUM_W-1:0]     num;
    logic [S_W:0]         trial;
    logic [COEF_W-1:0]    q_wr;

    always_comb begin
        int rp;
        rp        = int'(r_q);
        state_d   = state_q;
        n_d       = n_q;
        r_d       = r_q;
        d_d       = d_q;
        i_d       = i_q;
        j_d       = j_q;
        raw_d     = raw_q;
        acc_d     = acc_q;
        s_d       = s_q;
        rem_d     = rem_q;
        numlo_d   = numlo_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        sat_d     = sat_q;
        err_d     = err_q;
        aborted_d = aborted_q;
        work_d    = work_q;
        kernel_d  = kernel_q;
        sum_d     = sum_q;
        done_d    = 1'b0;
        p         = '0;
        num       = '0;
        trial     = '0;
        q_wr      = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    n_d       = bus.kernel_size;
                    for (int k = 0; k <= MAX_R; k++) raw_d[k] = bus.raw_w[k*IN_W +: IN_W];
                    r_d       = RW'((bus.kernel_size - KS_W'(1)) >> 1);
                    err_d     = 1'b0;
                    aborted_d = 1'b0;
                    state_d   = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!n_q[0] || int'(n_q) > MAX_KERNEL) begin
                    err_d   = 1'b1;
                    state_d = ST_FIN;
                end else begin
                    for (int k = 0; k < NK; k++) work_d[k] = '0;
                    acc_d   = '0;
                    d_d     = '0;
                    state_d = ST_SUM;
                end
            end
            ST_SUM: begin
                // Off-centre weights appear on both sides of the centre.
                acc_d = acc_q + ((d_q == '0) ? ACC_W'(raw_q[d_q]) : (ACC_W'(raw_q[d_q]) << 1));
                d_d   = d_q + 1'b1;
                if (d_q == r_q) state_d = ST_SQUARE;
            end
            ST_SQUARE: begin
                s_d = S_W'(acc_q) * S_W'(acc_q);
                if (s_d == '0) begin
                    err_d   = 1'b1;
                    state_d = ST_FIN;
                end else begin
                    i_d     = '0;
                    j_d     = '0;
                    state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                p = (2*IN_W)'(raw_q[i_q]) * (2*IN_W)'(raw_q[j_q]);
                num = (NUM_W'(p) << FRAC) + ((ROUND != 0) ? NUM_W'(s_q >> 1) : NUM_W'(0));
                // High part >= S means the quotient cannot fit COEF_W+1 bits.
                sat_d   = WIDE_W'(num >> (COEF_W + 1)) >= WIDE_W'(s_q);
                rem_d   = S_W'(num >> (COEF_W + 1));
                numlo_d = num[COEF_W:0];
                quo_d   = '0;
                cnt_d   = CW_W'(COEF_W);
                state_d = ST_DIV;
            end
            ST_DIV: begin
                trial   = {rem_q, numlo_q[COEF_W]};
                numlo_d = numlo_q << 1;
                if (trial >= {1'b0, s_q}) begin
                    rem_d = S_W'(trial - {1'b0, s_q});
                    quo_d = {quo_q[COEF_W-1:0], 1'b1};
                end else begin
                    rem_d = trial[S_W-1:0];
                    quo_d = {quo_q[COEF_W-1:0], 1'b0};
                end
                if (cnt_q == '0) state_d = ST_WR;
                else cnt_d = cnt_q - 1'b1;
            end
            ST_WR: begin
                q_wr = (sat_q || quo_q[COEF_W]) ? COEF_MAX : quo_q[COEF_W-1:0];
                work_d[IDX_W'((rp + int'(i_q)) * MAX_KERNEL + rp + int'(j_q))] = q_wr;
                work_d[IDX_W'((rp + int'(i_q)) * MAX_KERNEL + rp - int'(j_q))] = q_wr;
                work_d[IDX_W'((rp - int'(i_q)) * MAX_KERNEL + rp + int'(j_q))] = q_wr;
                work_d[IDX_W'((rp - int'(i_q)) * MAX_KERNEL + rp - int'(j_q))] = q_wr;
                if (j_q == r_q) begin
                    j_d = '0;
                    if (i_q == r_q) begin
                        state_d = ST_FIN;
                    end else begin
                        i_d     = i_q + 1'b1;
                        state_d = ST_MUL;
                    end
                end else begin
                    j_d     = j_q + 1'b1;
                    state_d = ST_MUL;
                end
            end
            ST_FIN: begin
                done_d = 1'b1;
                if (!err_q && !aborted_q && !bus.abort) begin
                    kernel_d = work_q;
                    sum_d    = s_q;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (bus.abort && state_q != ST_IDLE && state_q != ST_FIN) begin
            state_d   = ST_FIN;
            aborted_d = 1'b1;
            err_d     = err_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= ST_IDLE;
            n_q       <= '0;
            r_q       <= '0;
            d_q       <= '0;
            i_q       <= '0;
            j_q       <= '0;
            for (int k = 0; k <= MAX_R; k++) raw_q[k] <= '0;
            acc_q     <= '0;
            s_q       <= '0;
            rem_q     <= '0;
            numlo_q   <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            err_q     <= 1'b0;
            aborted_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            for (int k = 0; k < NK; k++) begin
                work_q[k]   <= '0;
                kernel_q[k] <= '0;
            end
            sum_q     <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            r_q       <= r_d;
            d_q       <= d_d;
            i_q       <= i_d;
            j_q       <= j_d;
            raw_q     <= raw_d;
            acc_q     <= acc_d;
            s_q       <= s_d;
            rem_q     <= rem_d;
            numlo_q   <= numlo_d;
            quo_q     <= quo_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
            err_q     <= err_d;
            aborted_q <= aborted_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            work_q    <= work_d;
            kernel_q  <= kernel_d;
            sum_q     <= sum_d;
        end
    end

    for (genvar g = 0; g < NK; g++) begin : g_kernel_out
        assign bus.kernel[g*COEF_W +: COEF_W] = kernel_q[g];
    end

    assign bus.sum_out = sum_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
endmodule
